// File: rtl/fft_r2_pair_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_r2_pair_buffer_if
// Purpose  : Sample-stream and butterfly-pair bundle for the radix-2 pairing
//            stage. The master is the upstream/sink side. The slave is the
//            pairing block.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_r2_pair_buffer_if #(
    parameter int DATA_W = 16
);
    // Serial input stream
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              sof;

    // Paired outputs toward the butterfly
    logic              up_valid;
    logic [DATA_W-1:0] up_data;
    logic              down_valid;
    logic [DATA_W-1:0] down_data;
    logic              busy;

    modport master (
        output in_valid, in_data, sof,
        input  up_valid, up_data, down_valid, down_data, busy
    );

    modport slave (
        input  in_valid, in_data, sof,
        output up_valid, up_data, down_valid, down_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/fft_r2_pair_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_r2_pair_buffer
// Purpose  : Radix-2 input pairing stage. Each 2*DEPTH-sample frame is
//            handled in two halves. The first half is buffered. As each
//            second-half sample k+DEPTH arrives, it is emitted together with
//            buffered sample k, one clock after it is accepted.
// Options  : FFT_PAIR_FRAME_ERR_EN adds a sticky truncated-frame flag
//            (frame_err) and a completed-frame counter (frame_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module fft_r2_pair_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,     // active-high asynchronous reset
    fft_r2_pair_buffer_if.slave  pb
`ifdef FFT_PAIR_FRAME_ERR_EN
    ,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
`endif
);
    localparam int CNT_W  = $clog2(2 * DEPTH);
    localparam int ADDR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(2 * DEPTH - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_w;
    logic [ADDR_W-1:0] addr_w;
    logic              pair_w;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              up_valid_q, up_valid_d;
    logic [DATA_W-1:0] up_data_q,  up_data_d;
    logic              dn_valid_q, dn_valid_d;
    logic [DATA_W-1:0] dn_data_q,  dn_data_d;
    logic              busy_q,     busy_d;

    // Effective index, phase, counter advance and next output pair
    always_comb begin
        idx_w      = pb.sof ? '0 : cnt_q;   // sof only matters when in_valid=1
        pair_w     = idx_w[CNT_W-1];        // upper half of frame = PAIR phase
        addr_w     = idx_w[ADDR_W-1:0];
        cnt_d      = cnt_q;
        up_valid_d = 1'b0;
        up_data_d  = '0;
        dn_valid_d = 1'b0;
        dn_data_d  = '0;
        if (pb.in_valid) begin
            cnt_d = idx_w + CNT_W'(1);      // 2*DEPTH is a power of 2, wraps naturally
            if (pair_w) begin
                up_valid_d = 1'b1;
                up_data_d  = mem_q[addr_w];
                dn_valid_d = 1'b1;
                dn_data_d  = pb.in_data;
            end
        end
        busy_d = (cnt_d != '0);
    end

    // Counter and registered output pair
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q      <= '0;
            up_valid_q <= 1'b0;
            up_data_q  <= '0;
            dn_valid_q <= 1'b0;
            dn_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            up_valid_q <= up_valid_d;
            up_data_q  <= up_data_d;
            dn_valid_q <= dn_valid_d;
            dn_data_q  <= dn_data_d;
            busy_q     <= busy_d;
        end
    end

    // First-half buffer. It is not reset. Reads and writes hit disjoint phases.
    always_ff @(posedge clk) begin
        if (pb.in_valid && !pair_w) begin
            mem_q[addr_w] <= pb.in_data;
        end
    end

    assign pb.up_valid   = up_valid_q;
    assign pb.up_data    = up_data_q;
    assign pb.down_valid = dn_valid_q;
    assign pb.down_data  = dn_data_q;
    assign pb.busy       = busy_q;

`ifdef FFT_PAIR_FRAME_ERR_EN
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Truncation detect (sof mid-frame) and completed-frame count
    always_comb begin
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;
        if (pb.in_valid && pb.sof && (cnt_q != '0)) begin
            frame_err_d = 1'b1;
        end
        if (pb.in_valid && (idx_w == C_LAST)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Sticky error flag and frame counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
`endif
endmodule
`default_nettype wire

// File: doc/fft_r2_pair_buffer.md
Name: fft_r2_pair_buffer

Overview:
Radix-2 input pairing stage that sits directly upstream of the 2-point butterfly. It accepts one serial stream of FFT_DATA_BUS samples and buffers the first half of each 2*DEPTH-sample frame. As the second half arrives, it presents sample k and sample k+DEPTH together on the up and down buses, which the butterfly consumes. There is no backpressure: the butterfly accepts every cycle, so this block never stalls.

Parameters:
DEPTH, 8, half-frame length in samples; power of 2, minimum 2; internal buffer is DEPTH entries of FFT_DATA_SAMPLE.
CNT_W, $clog2(2*DEPTH), width of the internal sample counter; derived, do not override.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active-high (1 = reset asserted); name kept for .* connection with neighbouring stages.
in  input  $bits(FFT_DATA_BUS)  serial sample stream; in.valid qualifies in.data.
sof  input  1  start-of-frame; meaningful only when in.valid=1; forces the current sample to be frame index 0.
up  output  $bits(FFT_DATA_BUS)  sample k of the current frame, to butterfly up.
down  output  $bits(FFT_DATA_BUS)  sample k+DEPTH of the current frame, to butterfly down.
busy  output  1  1 while a frame is partially received (cnt != 0).

Behaviour:
- Reset (async, rst_n=1): cnt=0, up=0, down=0 (valid and data both zero), busy=0. Buffer contents are don't-care and are not reset.
- Counter: cnt advances only on cycles with in.valid=1. It wraps from 2*DEPTH-1 to 0. Cycles with in.valid=0 leave cnt, the buffer and the phase unchanged.
- sof with in.valid=1: the sample is treated as index 0, regardless of cnt. It is written to buf[0] and cnt becomes 1. Any partial frame is discarded; no pair is output for it.
- FILL phase (effective index i < DEPTH): buf[i] <= in.data. On the next cycle, up.valid=0 and down.valid=0.
- PAIR phase (i >= DEPTH): on the next edge, registered outputs take:
  - up.data = buf[i-DEPTH], up.valid = 1
  - down.data = in.data, down.valid = 1
- Latency: exactly 1 clk from the accepting edge of the second-half sample to up/down valid. up and down are always valid together. Within a frame, pairs come out in order k = 0..DEPTH-1.
- Idle cycles inside PAIR phase produce a valid=0 bubble on both outputs. The pair resumes on the next valid input.
- When outputs are not valid, up.data and down.data are driven 0. This matches the butterfly's input gating.
- No arithmetic is performed. Data is passed bit-exact, with width set by FFT_DATA_SAMPLE.
- Back-to-back frames: after index 2*DEPTH-1 the next valid sample is index 0 of a new frame, with no gap cycle needed. Read of buf[i-DEPTH] and write of new FILL data never collide, because their phases are disjoint.
- busy = (cnt != 0), registered, so it is 0 after reset.
- Reset asserted mid-frame: outputs clear immediately, asynchronously. After release, the first valid sample is index 0.

Optional Feature:
FFT_PAIR_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit), sticky and cleared only by reset.
  - Set one cycle after any sof with in.valid=1 that arrives while cnt != 0 (truncated frame).
  - Also adds output frame_cnt (16 bits), which increments on every completed frame (index 2*DEPTH-1 accepted) and wraps at 0xFFFF.
- Undefined: neither port exists, and no error-tracking logic is built.

Test Plan:
1. DEPTH=4; reset, then 8 contiguous valid samples 1..8 with sof on sample 1 -> pairs (1,5),(2,6),(3,7),(4,8) on up/down, the first pair one cycle after sample 5. Outputs are valid=0 during the fill; busy falls after sample 8.
2. DEPTH=4; samples 1..8 with in.valid=0 inserted after samples 2 and 6 -> same four pairs, with a one-cycle valid=0 bubble (data 0) after pair (2,6). No pair is duplicated.
3. DEPTH=4; two back-to-back frames, samples 1..16 with no gaps -> pairs (1,5)..(4,8), then (9,13)..(12,16), with no lost cycle between frames.
4. DEPTH=4; samples 1..6, then sof with sample 21 followed by 22..28 -> only (21,25)..(24,28) are output. With FFT_PAIR_FRAME_ERR_EN defined, frame_err=1 and frame_cnt=1 at the end.
5. Assert rst_n=1 during the pair phase (after sample 6 of a frame) -> up/down go to 0 asynchronously. After release, samples 31..38 produce (31,35)..(34,38).
6. Connect to the 2-point butterfly, DEPTH=2, input 3,5,1,2 -> add_out data = 4, 7 and sub_out data = 2, 3 at the butterfly's documented latencies.
